// File: rtl/vid_timing_pkg.sv
// vid_timing_pkg: shared widths, mode table, state and measurement types for the timing detector
package vid_timing_pkg;
  localparam int CW = 12;
  localparam int WW = 22;
  localparam int NMODES = 6;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [WW-1:0] WD_MAX = '1;
  localparam logic [3:0] MODE_640X480 = 4'd0;
  localparam logic [3:0] MODE_720X480 = 4'd1;
  localparam logic [3:0] MODE_1024X768 = 4'd2;
  localparam logic [3:0] MODE_1280X1024 = 4'd3;
  localparam logic [3:0] MODE_800X480 = 4'd4;
  localparam logic [3:0] MODE_1080P = 4'd5;
  localparam logic [3:0] MODE_NONE = 4'hF;
  localparam logic [CW-1:0] MODE_HT [NMODES] = '{12'd800, 12'd858, 12'd1344, 12'd1688, 12'd1120, 12'd2200};
  localparam logic [CW-1:0] MODE_VT [NMODES] = '{12'd525, 12'd525, 12'd806, 12'd1066, 12'd518, 12'd1125};
  localparam logic [3:0] MODE_ID [NMODES] = '{MODE_640X480, MODE_720X480, MODE_1024X768, MODE_1280X1024, MODE_800X480, MODE_1080P};
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  typedef struct packed {
    logic [CW-1:0] ht;
    logic [CW-1:0] ha;
    logic [CW-1:0] hs;
    logic [CW-1:0] vt;
    logic [CW-1:0] va;
    logic [CW-1:0] vs;
  } meas_t;
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic inc);
    return c + CW'(inc && c != CMAX);
  endfunction
  function automatic logic [3:0] decode_mode(input logic [CW-1:0] ht, input logic [CW-1:0] vt);
    logic [3:0] m;
    m = MODE_NONE;
    for (int i = 0; i < NMODES; i++)
      if (ht == MODE_HT[i] && vt == MODE_VT[i]) m = MODE_ID[i];
    return m;
  endfunction
endpackage

// File: rtl/vid_edge_det.sv
// vid_edge_det: samples the sync/DE inputs once and flags HS/VS rising edges on the sampled copies
module vid_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic hs,
  input  logic vs,
  input  logic de,
  output logic hs_s,
  output logic vs_s,
  output logic de_s,
  output logic hs_rise,
  output logic vs_rise
);
  logic hs_d, vs_d;
  // first stage samples the inputs, second stage holds the previous sample for edge compare
  always_ff @(posedge clk) begin
    if (reset) begin
      {hs_s, vs_s, de_s} <= '0;
      {hs_d, vs_d} <= '0;
    end else begin
      {hs_s, vs_s, de_s} <= {hs, vs, de};
      {hs_d, vs_d} <= {hs_s, vs_s};
    end
  end
  assign hs_rise = hs_s & ~hs_d;
  assign vs_rise = vs_s & ~vs_d;
endmodule

// File: rtl/vid_timing_detector.sv
// vid_timing_detector: measures line/frame timing of a video stream, decodes the mode and tracks lock
module vid_timing_detector import vid_timing_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic vid_hs,
  input  logic vid_vs,
  input  logic vid_de,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] h_sync,
  output logic [11:0] v_total,
  output logic [11:0] v_active,
  output logic [11:0] v_sync,
  output logic [3:0] mode,
  output logic locked,
  output logic mode_change
);
  logic hs_s, vs_s, de_s, hs_rise, vs_rise;
  logic [CW-1:0] h_cnt, de_cnt, hsw_cnt, v_cnt, va_cnt, vsl_cnt, ht_lat, ha_lat, hsw_lat;
  logic vs_seen, f_ovf, line_de, line_vs, ovf_now, valid, pv, pv_n, locked_n;
  logic [WW-1:0] wd;
  logic [3:0] mode_n;
  meas_t frame, meas, meas_n, prev, prev_n;
  state_t state, state_n;

  vid_edge_det u_edge (
    .clk(clk),
    .reset(reset),
    .hs(vid_hs),
    .vs(vid_vs),
    .de(vid_de),
    .hs_s(hs_s),
    .vs_s(vs_s),
    .de_s(de_s),
    .hs_rise(hs_rise),
    .vs_rise(vs_rise)
  );

  assign line_de = hs_rise && de_cnt != '0;
  assign line_vs = hs_rise && vs_seen;
  assign ovf_now = (!hs_rise && (h_cnt == CMAX || (de_s && de_cnt == CMAX) || (hs_s && hsw_cnt == CMAX)))
                || (!vs_rise && hs_rise && v_cnt == CMAX)
                || (line_de && va_cnt == CMAX) || (line_vs && vsl_cnt == CMAX);
  assign valid = !(f_ovf || ovf_now);
  assign frame = '{ht: hs_rise ? h_cnt : ht_lat,
                   ha: line_de ? de_cnt : ha_lat,
                   hs: line_de ? hsw_cnt : hsw_lat,
                   vt: v_cnt,
                   va: sat_inc(va_cnt, line_de),
                   vs: sat_inc(vsl_cnt, line_vs)};

  // per-line and per-frame saturating counters; a line closes on HS rise, a frame on VS rise
  always_ff @(posedge clk) begin
    if (reset) begin
      {h_cnt, de_cnt, hsw_cnt, v_cnt, va_cnt, vsl_cnt} <= '0;
      {ht_lat, ha_lat, hsw_lat} <= '0;
      vs_seen <= 1'b0;
      f_ovf <= 1'b0;
      wd <= '0;
    end else begin
      h_cnt <= hs_rise ? CW'(1) : sat_inc(h_cnt, 1'b1);
      de_cnt <= hs_rise ? CW'(de_s) : sat_inc(de_cnt, de_s);
      hsw_cnt <= hs_rise ? CW'(hs_s) : sat_inc(hsw_cnt, hs_s);
      vs_seen <= hs_rise ? vs_s : (vs_seen | vs_s);
      ht_lat <= frame.ht;
      ha_lat <= vs_rise ? '0 : frame.ha;
      hsw_lat <= vs_rise ? '0 : frame.hs;
      v_cnt <= vs_rise ? CW'(hs_rise) : sat_inc(v_cnt, hs_rise);
      va_cnt <= vs_rise ? '0 : frame.va;
      vsl_cnt <= vs_rise ? '0 : frame.vs;
      f_ovf <= !vs_rise && (f_ovf || ovf_now);
      wd <= vs_rise ? '0 : wd + WW'(1);
    end
  end

  // next state: VS rise commits a frame (discarded in SEARCH), watchdog expiry drops to SEARCH
  always_comb begin
    state_n = state;
    meas_n = meas;
    prev_n = prev;
    pv_n = pv;
    if (vs_rise) begin
      if (state == SEARCH) begin
        state_n = MEASURE;
        pv_n = 1'b0;
      end else begin
        meas_n = frame;
        prev_n = frame;
        pv_n = valid;
        state_n = (valid && pv && frame == prev) ? LOCKED : MEASURE;
      end
    end else if (wd == WD_MAX) begin
      state_n = SEARCH;
    end
    locked_n = state_n == LOCKED;
    mode_n = locked_n ? decode_mode(meas_n.ht, meas_n.vt) : MODE_NONE;
  end

  // state, reported measurements and status; mode_change flags any {locked, mode} transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
      meas <= '0;
      prev <= '0;
      pv <= 1'b0;
      locked <= 1'b0;
      mode <= MODE_NONE;
      mode_change <= 1'b0;
    end else begin
      state <= state_n;
      meas <= meas_n;
      prev <= prev_n;
      pv <= pv_n;
      locked <= locked_n;
      mode <= mode_n;
      mode_change <= {locked_n, mode_n} != {locked, mode};
    end
  end

  assign h_total = meas.ht;
  assign h_active = meas.ha;
  assign h_sync = meas.hs;
  assign v_total = meas.vt;
  assign v_active = meas.va;
  assign v_sync = meas.vs;
endmodule

// File: tb/tb_vid_timing_detector.sv
// tb_vid_timing_detector: directed scenarios driving synthetic video timings into the detector
module tb_vid_timing_detector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vid_hs = 1'b0;
  logic vid_vs = 1'b0;
  logic vid_de = 1'b0;
  logic [11:0] h_total, h_active, h_sync, v_total, v_active, v_sync;
  logic [3:0] mode;
  logic locked, mode_change;
  int cur[6];
  int nxt[6];
  int hc = 0;
  int vc = 0;
  int vs_edges = 0;
  int mc = 0;
  int pass_cnt = 0;
  int total = 0;
  logic gen_on = 1'b0;
  logic vs_en = 1'b1;

  vid_timing_detector dut (
    .clk(clk),
    .reset(reset),
    .vid_hs(vid_hs),
    .vid_vs(vid_vs),
    .vid_de(vid_de),
    .h_total(h_total),
    .h_active(h_active),
    .h_sync(h_sync),
    .v_total(v_total),
    .v_active(v_active),
    .v_sync(v_sync),
    .mode(mode),
    .locked(locked),
    .mode_change(mode_change)
  );

  always #5 clk = ~clk;

  task automatic set_timing(input int ht, input int ha, input int hs, input int vt, input int va, input int vs);
    nxt = '{ht, ha, hs, vt, va, vs};
  endtask

  task automatic step();
    int dh, dv;
    @(negedge clk);
    mc += int'(mode_change);
    if (gen_on) begin
      if (hc == 0 && vc == 0) begin
        cur = nxt;
        if (vs_en) vs_edges++;
      end
      dh = cur[2] + (cur[0] - cur[2] - cur[1]) / 2;
      dv = cur[5] + (cur[3] - cur[5] - cur[4]) / 2;
      vid_hs = hc < cur[2];
      vid_vs = vs_en && vc < cur[5];
      vid_de = hc >= dh && hc < dh + cur[1] && vc >= dv && vc < dv + cur[4];
      hc++;
      if (hc == cur[0]) begin
        hc = 0;
        vc = (vc + 1 == cur[3]) ? 0 : vc + 1;
      end
    end else begin
      {vid_hs, vid_vs, vid_de} = 3'b000;
    end
  endtask

  task automatic run_clocks(input int n);
    repeat (n) step();
  endtask

  task automatic run_vs(input int k);
    int target, budget;
    target = vs_edges + k;
    budget = 8000000;
    while (vs_edges < target && budget > 0) begin
      step();
      budget--;
    end
    total++; if (vs_edges < target) $display("FAIL vs_wait: edges %0d required %0d", vs_edges, target); else pass_cnt++;
    run_clocks(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run_clocks(4);
    total++; if (h_total !== 12'd0) $display("FAIL rst h_total: got %0d expected 0", h_total); else pass_cnt++;
    total++; if (h_active !== 12'd0) $display("FAIL rst h_active: got %0d expected 0", h_active); else pass_cnt++;
    total++; if (h_sync !== 12'd0) $display("FAIL rst h_sync: got %0d expected 0", h_sync); else pass_cnt++;
    total++; if (v_total !== 12'd0) $display("FAIL rst v_total: got %0d expected 0", v_total); else pass_cnt++;
    total++; if (v_active !== 12'd0) $display("FAIL rst v_active: got %0d expected 0", v_active); else pass_cnt++;
    total++; if (v_sync !== 12'd0) $display("FAIL rst v_sync: got %0d expected 0", v_sync); else pass_cnt++;
    total++; if (mode !== 4'hF) $display("FAIL rst mode: got %0h expected f", mode); else pass_cnt++;
    total++; if (locked !== 1'b0) $display("FAIL rst locked: got %0b expected 0", locked); else pass_cnt++;
    total++; if (mode_change !== 1'b0) $display("FAIL rst mode_change: got %0b expected 0", mode_change); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_640();
    set_timing(800, 640, 96, 525, 480, 2);
    hc = 0;
    vc = 0;
    mc = 0;
    gen_on = 1'b1;
    run_vs(2);
    total++; if (locked !== 1'b0) $display("FAIL 640 early locked: got %0b expected 0", locked); else pass_cnt++;
    total++; if (mode !== 4'hF) $display("FAIL 640 early mode: got %0h expected f", mode); else pass_cnt++;
    total++; if (h_total !== 12'd800) $display("FAIL 640 early h_total: got %0d expected 800", h_total); else pass_cnt++;
    total++; if (v_total !== 12'd525) $display("FAIL 640 early v_total: got %0d expected 525", v_total); else pass_cnt++;
    run_vs(1);
    total++; if (locked !== 1'b1) $display("FAIL 640 locked: got %0b expected 1", locked); else pass_cnt++;
    total++; if (mode !== 4'd0) $display("FAIL 640 mode: got %0h expected 0", mode); else pass_cnt++;
    total++; if (h_total !== 12'd800) $display("FAIL 640 h_total: got %0d expected 800", h_total); else pass_cnt++;
    total++; if (h_active !== 12'd640) $display("FAIL 640 h_active: got %0d expected 640", h_active); else pass_cnt++;
    total++; if (h_sync !== 12'd96) $display("FAIL 640 h_sync: got %0d expected 96", h_sync); else pass_cnt++;
    total++; if (v_total !== 12'd525) $display("FAIL 640 v_total: got %0d expected 525", v_total); else pass_cnt++;
    total++; if (v_active !== 12'd480) $display("FAIL 640 v_active: got %0d expected 480", v_active); else pass_cnt++;
    total++; if (v_sync !== 12'd2) $display("FAIL 640 v_sync: got %0d expected 2", v_sync); else pass_cnt++;
    total++; if (mc !== 1) $display("FAIL 640 pulses: got %0d expected 1", mc); else pass_cnt++;
  endtask

  task automatic test_switch();
    mc = 0;
    set_timing(1688, 1280, 112, 1066, 1024, 3);
    run_vs(1);
    total++; if (locked !== 1'b1) $display("FAIL sw hold locked: got %0b expected 1", locked); else pass_cnt++;
    total++; if (mc !== 0) $display("FAIL sw hold pulses: got %0d expected 0", mc); else pass_cnt++;
    run_vs(1);
    total++; if (locked !== 1'b0) $display("FAIL sw drop locked: got %0b expected 0", locked); else pass_cnt++;
    total++; if (mode !== 4'hF) $display("FAIL sw drop mode: got %0h expected f", mode); else pass_cnt++;
    total++; if (mc !== 1) $display("FAIL sw drop pulses: got %0d expected 1", mc); else pass_cnt++;
    total++; if (h_total !== 12'd1688) $display("FAIL sw drop h_total: got %0d expected 1688", h_total); else pass_cnt++;
    total++; if (v_total !== 12'd1066) $display("FAIL sw drop v_total: got %0d expected 1066", v_total); else pass_cnt++;
    run_vs(1);
    total++; if (locked !== 1'b1) $display("FAIL sw relock locked: got %0b expected 1", locked); else pass_cnt++;
    total++; if (mode !== 4'd3) $display("FAIL sw relock mode: got %0h expected 3", mode); else pass_cnt++;
    total++; if (mc !== 2) $display("FAIL sw relock pulses: got %0d expected 2", mc); else pass_cnt++;
    total++; if (h_active !== 12'd1280) $display("FAIL sw h_active: got %0d expected 1280", h_active); else pass_cnt++;
    total++; if (h_sync !== 12'd112) $display("FAIL sw h_sync: got %0d expected 112", h_sync); else pass_cnt++;
    total++; if (v_active !== 12'd1024) $display("FAIL sw v_active: got %0d expected 1024", v_active); else pass_cnt++;
    total++; if (v_sync !== 12'd3) $display("FAIL sw v_sync: got %0d expected 3", v_sync); else pass_cnt++;
  endtask

  task automatic test_watchdog();
    mc = 0;
    vs_en = 1'b0;
    run_clocks((1 << 22) - 20);
    total++; if (locked !== 1'b1) $display("FAIL wd before locked: got %0b expected 1", locked); else pass_cnt++;
    total++; if (mode !== 4'd3) $display("FAIL wd before mode: got %0h expected 3", mode); else pass_cnt++;
    run_clocks(40);
    total++; if (locked !== 1'b0) $display("FAIL wd locked: got %0b expected 0", locked); else pass_cnt++;
    total++; if (mode !== 4'hF) $display("FAIL wd mode: got %0h expected f", mode); else pass_cnt++;
    total++; if (mc !== 1) $display("FAIL wd pulses: got %0d expected 1", mc); else pass_cnt++;
    total++; if (h_total !== 12'd1688) $display("FAIL wd h_total: got %0d expected 1688", h_total); else pass_cnt++;
    total++; if (v_total !== 12'd1066) $display("FAIL wd v_total: got %0d expected 1066", v_total); else pass_cnt++;
    total++; if (h_active !== 12'd1280) $display("FAIL wd h_active: got %0d expected 1280", h_active); else pass_cnt++;
    total++; if (v_sync !== 12'd3) $display("FAIL wd v_sync: got %0d expected 3", v_sync); else pass_cnt++;
  endtask

  task automatic test_overflow();
    mc = 0;
    set_timing(5000, 4200, 200, 10, 6, 2);
    vs_en = 1'b1;
    run_vs(4);
    total++; if (locked !== 1'b0) $display("FAIL ovf locked: got %0b expected 0", locked); else pass_cnt++;
    total++; if (mode !== 4'hF) $display("FAIL ovf mode: got %0h expected f", mode); else pass_cnt++;
    total++; if (mc !== 0) $display("FAIL ovf pulses: got %0d expected 0", mc); else pass_cnt++;
    total++; if (h_total !== 12'd4095) $display("FAIL ovf h_total: got %0d expected 4095", h_total); else pass_cnt++;
    total++; if (h_active !== 12'd4095) $display("FAIL ovf h_active: got %0d expected 4095", h_active); else pass_cnt++;
    total++; if (h_sync !== 12'd200) $display("FAIL ovf h_sync: got %0d expected 200", h_sync); else pass_cnt++;
    total++; if (v_total !== 12'd10) $display("FAIL ovf v_total: got %0d expected 10", v_total); else pass_cnt++;
    total++; if (v_active !== 12'd6) $display("FAIL ovf v_active: got %0d expected 6", v_active); else pass_cnt++;
    total++; if (v_sync !== 12'd2) $display("FAIL ovf v_sync: got %0d expected 2", v_sync); else pass_cnt++;
  endtask

  task automatic test_800x480();
    mc = 0;
    set_timing(1120, 797, 32, 518, 480, 3);
    run_vs(2);
    total++; if (locked !== 1'b0) $display("FAIL 800 early locked: got %0b expected 0", locked); else pass_cnt++;
    run_vs(1);
    total++; if (locked !== 1'b1) $display("FAIL 800 locked: got %0b expected 1", locked); else pass_cnt++;
    total++; if (mode !== 4'd4) $display("FAIL 800 mode: got %0h expected 4", mode); else pass_cnt++;
    total++; if (h_total !== 12'd1120) $display("FAIL 800 h_total: got %0d expected 1120", h_total); else pass_cnt++;
    total++; if (h_active !== 12'd797) $display("FAIL 800 h_active: got %0d expected 797", h_active); else pass_cnt++;
    total++; if (h_sync !== 12'd32) $display("FAIL 800 h_sync: got %0d expected 32", h_sync); else pass_cnt++;
    total++; if (v_total !== 12'd518) $display("FAIL 800 v_total: got %0d expected 518", v_total); else pass_cnt++;
    total++; if (v_active !== 12'd480) $display("FAIL 800 v_active: got %0d expected 480", v_active); else pass_cnt++;
    total++; if (v_sync !== 12'd3) $display("FAIL 800 v_sync: got %0d expected 3", v_sync); else pass_cnt++;
    total++; if (mc !== 1) $display("FAIL 800 pulses: got %0d expected 1", mc); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    run_clocks(5000);
    reset = 1'b1;
    run_clocks(1);
    total++; if (h_total !== 12'd0) $display("FAIL mid h_total: got %0d expected 0", h_total); else pass_cnt++;
    total++; if (h_active !== 12'd0) $display("FAIL mid h_active: got %0d expected 0", h_active); else pass_cnt++;
    total++; if (v_total !== 12'd0) $display("FAIL mid v_total: got %0d expected 0", v_total); else pass_cnt++;
    total++; if (v_active !== 12'd0) $display("FAIL mid v_active: got %0d expected 0", v_active); else pass_cnt++;
    total++; if (mode !== 4'hF) $display("FAIL mid mode: got %0h expected f", mode); else pass_cnt++;
    total++; if (locked !== 1'b0) $display("FAIL mid locked: got %0b expected 0", locked); else pass_cnt++;
    total++; if (mode_change !== 1'b0) $display("FAIL mid mode_change: got %0b expected 0", mode_change); else pass_cnt++;
    run_clocks(3);
    reset = 1'b0;
    mc = 0;
    run_vs(2);
    total++; if (locked !== 1'b0) $display("FAIL mid two-edge locked: got %0b expected 0", locked); else pass_cnt++;
    total++; if (mode !== 4'hF) $display("FAIL mid two-edge mode: got %0h expected f", mode); else pass_cnt++;
    run_vs(1);
    total++; if (locked !== 1'b1) $display("FAIL mid relock locked: got %0b expected 1", locked); else pass_cnt++;
    total++; if (mode !== 4'd4) $display("FAIL mid relock mode: got %0h expected 4", mode); else pass_cnt++;
    total++; if (h_active !== 12'd797) $display("FAIL mid relock h_active: got %0d expected 797", h_active); else pass_cnt++;
    total++; if (mc !== 1) $display("FAIL mid relock pulses: got %0d expected 1", mc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_640();
    test_switch();
    test_watchdog();
    test_overflow();
    test_800x480();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
